calc_core: RTL and testbench
============================

Name: calc_core

Overview:
- Consumer of the keypad_driver eBCD key stream and producer of the signed fnd_serial word that segment_driver renders.
- Implements the calculator: operand entry, operator selection, arithmetic, and result/error display.
- Sits between keypad_driver and segment_driver in the calculator top level, clocked by sw_clk from clock_divider.

Parameters:
- IDLE_CODE, 5'h1F, eBCD value meaning "no key pressed"
- MAX_POS, 999999, largest displayable value (6 digits)
- MIN_NEG, -99999, smallest displayable value (sign uses one digit)

Ports:
- sw_clk  input  1  system clock for the block (from clock_divider)
- rst  input  1  asynchronous, active-high reset
- eBCD  input  5  key code: 0-9 digit, 10 PLUS, 11 MINUS, 12 MUL, 13 DIV, 14 MOD, 15 EQUAL, 31 idle; 16-30 ignored
- fnd_serial  output  32  signed display word to segment_driver
- err  output  1  high while in ERROR state
- key_ack  output  1  one-cycle pulse per accepted key

Behaviour:
- Reset (async, rst=1) values:
  - fnd_serial=0, err=0, key_ack=0
  - state=ENTER_A, a=0, b=0, op=PLUS
  - eBCD_q=IDLE_CODE
- Key accept:
  - key_stb = (eBCD!=IDLE_CODE) && (eBCD!=eBCD_q); eBCD_q is registered every cycle.
  - A held key is accepted exactly once. The same key pressed again needs an intervening idle.
  - Codes 16-30 produce no key_stb.
- Latency: fnd_serial, err and key_ack update on the sw_clk edge after the accepting cycle (1 cycle, registered).
- Display codes:
  - operator shown as 'h0010_0000 PLUS, 'h0020_0000 MINUS, 'h0030_0000 MUL, 'h0040_0000 DIV, 'h0050_0000 MOD
  - error shown as 'h00EE_0000
- States:
  - ENTER_A:
    - digit d: a<=a*10+d if a<=99999, else ignored; display a.
    - operator: op<=code; go to SHOW_OP; display operator code.
    - EQUAL: ignored.
  - SHOW_OP:
    - digit d: b<=d; go to ENTER_B; display b.
    - operator: op replaced; display new code.
    - EQUAL: ignored.
  - ENTER_B:
    - digit: append as in ENTER_A, into b.
    - EQUAL: compute a op b.
      - ok: result to a; go to SHOW_RES; display result.
      - error: go to ERROR.
    - operator (chaining): compute.
      - ok: a<=result, op<=new code; go to SHOW_OP.
      - error: go to ERROR.
  - SHOW_RES:
    - digit d: a<=d; go to ENTER_A (new calculation).
    - operator: keep a; op<=code; go to SHOW_OP.
    - EQUAL: ignored.
  - ERROR:
    - digit d: a<=d, err<=0; go to ENTER_A.
    - operator/EQUAL: ignored.
    - Display stays 'h00EE_0000 until a digit or rst.
- Arithmetic:
  - Operands are 32-bit signed; the product is evaluated in 64 bits.
  - DIV truncates toward zero; MOD result takes the dividend's sign (Verilog semantics).
  - DIV or MOD by b=0 is an error.
  - A result outside [MIN_NEG, MAX_POS] is an error.
- Operand entry is non-negative only. Negative values arise only as results and may be chained as a.
- Leading zeros: digit 0 with a=0 keeps a=0.
- rst asserted mid-operation: immediate return to reset values regardless of state; no pending key is replayed after release (eBCD_q=IDLE_CODE, so a still-held key is accepted once after release of rst).

Decomposition:
- Shared header calc_defs.vh holds:
  - eBCD code constants (digits, PLUS..EQUAL, IDLE_CODE)
  - display code constants (operator codes, ERROR 'h00EE_0000)
  - FSM state encoding
  - MAX_POS/MIN_NEG
- Sub-module calc_alu, purely combinational:
  - inputs a, b, op
  - outputs result[31:0] and alu_err (div/mod by zero, range overflow)
  - Instantiated once in calc_core.

Test Plan:
- Reset then release -> fnd_serial=0, err=0, key_ack silent with eBCD=31.
- Keys 1,2,+,3,= (each separated by idle) -> fnd_serial 1, 12, 'h0010_0000, 3, 15; one key_ack per key.
- Division by zero and recovery:
  - 7,/,0,= -> 'h00EE_0000, err=1.
  - Then + -> unchanged.
  - Then 5 -> fnd_serial=5, err=0.
- Negative result and chaining:
  - 3,-,8,= -> -5.
  - Then *,4,= -> 'h0030_0000, 4, -20.
  - Then 1,7,%,5,= -> 2.
- Entry limit and overflow:
  - 1,2,3,4,5,6,7 -> stays 123456.
  - Fresh 9,9,9,9,9,9,*,2,= -> 'h00EE_0000.
  - 5,-,9,9,9,9,9,9,= -> 'h00EE_0000 (below MIN_NEG).
- Key handling and reset:
  - Hold eBCD=5 for 10 cycles -> single accept, fnd_serial=5.
  - 5,idle,5 -> 55.
  - Assert rst during ENTER_B -> fnd_serial=0 asynchronously, state ENTER_A.

Source files
------------

// File: rtl/calc_core_pkg.sv
// Shared key codes, display words, state encoding and helpers for the calculator core.
package calc_core_pkg;

  localparam logic [4:0] KEY_MAX_DIGIT = 5'd9;
  localparam logic [4:0] KEY_PLUS      = 5'd10;
  localparam logic [4:0] KEY_MINUS     = 5'd11;
  localparam logic [4:0] KEY_MUL       = 5'd12;
  localparam logic [4:0] KEY_DIV       = 5'd13;
  localparam logic [4:0] KEY_MOD       = 5'd14;
  localparam logic [4:0] KEY_EQUAL     = 5'd15;
  localparam logic [4:0] IDLE_CODE     = 5'h1F;

  localparam logic [31:0] DISP_PLUS  = 32'h0010_0000;
  localparam logic [31:0] DISP_MINUS = 32'h0020_0000;
  localparam logic [31:0] DISP_MUL   = 32'h0030_0000;
  localparam logic [31:0] DISP_DIV   = 32'h0040_0000;
  localparam logic [31:0] DISP_MOD   = 32'h0050_0000;
  localparam logic [31:0] DISP_ERROR = 32'h00EE_0000;

  localparam logic signed [63:0] MAX_POS     = 64'sd999999;
  localparam logic signed [63:0] MIN_NEG     = -64'sd99999;
  localparam logic signed [31:0] ENTRY_LIMIT = 32'sd99999;

  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_SHOW_OP  = 3'd1,
    ST_ENTER_B  = 3'd2,
    ST_SHOW_RES = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [4:0] code);
    return (code <= KEY_MAX_DIGIT);
  endfunction

  function automatic logic is_oper(input logic [4:0] code);
    return (code >= KEY_PLUS) && (code <= KEY_MOD);
  endfunction

  function automatic logic [31:0] op_display(input logic [4:0] code);
    logic [31:0] disp;
    case (code)
      KEY_PLUS:  disp = DISP_PLUS;
      KEY_MINUS: disp = DISP_MINUS;
      KEY_MUL:   disp = DISP_MUL;
      KEY_DIV:   disp = DISP_DIV;
      KEY_MOD:   disp = DISP_MOD;
      default:   disp = 32'h0000_0000;
    endcase
    return disp;
  endfunction

  // Shift in one decimal digit unless the operand already fills six digits.
  function automatic logic signed [31:0] append_digit(input logic signed [31:0] val,
                                                      input logic [4:0] d);
    logic signed [31:0] res;
    if (val <= ENTRY_LIMIT) begin
      res = val * 32'sd10 + $signed({27'd0, d});
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/calc_core_alu.sv
// Combinational arithmetic unit: a op b with divide-by-zero and display-range checking.
module calc_alu
  import calc_core_pkg::*;
(
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  input  logic [4:0]         op,
  output logic [31:0]        result,
  output logic               alu_err
);

  logic signed [63:0] a_wide_s;
  logic signed [63:0] b_wide_s;
  logic signed [63:0] b_safe_s;
  logic signed [63:0] wide_s;
  logic               div_zero_s;

  // Evaluate in 64 bits so the product and range check cannot wrap.
  always_comb begin
    a_wide_s   = {{32{a[31]}}, a};
    b_wide_s   = {{32{b[31]}}, b};
    b_safe_s   = (b_wide_s == 64'sd0) ? 64'sd1 : b_wide_s;
    div_zero_s = 1'b0;
    wide_s     = 64'sd0;
    case (op)
      KEY_PLUS:  wide_s = a_wide_s + b_wide_s;
      KEY_MINUS: wide_s = a_wide_s - b_wide_s;
      KEY_MUL:   wide_s = a_wide_s * b_wide_s;
      KEY_DIV: begin
        div_zero_s = (b_wide_s == 64'sd0);
        wide_s     = a_wide_s / b_safe_s;
      end
      KEY_MOD: begin
        div_zero_s = (b_wide_s == 64'sd0);
        wide_s     = a_wide_s % b_safe_s;
      end
      default:   wide_s = 64'sd0;
    endcase
    alu_err = div_zero_s || (wide_s > MAX_POS) || (wide_s < MIN_NEG);
    result  = wide_s[31:0];
  end

endmodule

// File: rtl/calc_core.sv
// Calculator core: accepts edge-detected eBCD keys, runs the entry FSM and drives the display word.
module calc_core
  import calc_core_pkg::*;
(
  input  logic        sw_clk,
  input  logic        rst,
  input  logic [4:0]  eBCD,
  output logic [31:0] fnd_serial,
  output logic        err,
  output logic        key_ack
);

  state_t             state_r;
  state_t             state_nxt_s;
  logic signed [31:0] a_r;
  logic signed [31:0] b_r;
  logic [4:0]         op_r;
  logic [4:0]         ebcd_q_r;
  logic signed [31:0] a_nxt_s;
  logic signed [31:0] b_nxt_s;
  logic [4:0]         op_nxt_s;
  logic [31:0]        disp_nxt_s;
  logic               err_nxt_s;
  logic               key_stb_s;
  logic               digit_s;
  logic               oper_s;
  logic               equal_s;
  logic signed [31:0] digit_val_s;
  logic [31:0]        alu_result_s;
  logic               alu_err_s;

  assign key_stb_s   = (eBCD != IDLE_CODE) && (eBCD != ebcd_q_r) && (eBCD <= KEY_EQUAL);
  assign digit_s     = is_digit(eBCD);
  assign oper_s      = is_oper(eBCD);
  assign equal_s     = (eBCD == KEY_EQUAL);
  assign digit_val_s = $signed({27'd0, eBCD});

  calc_alu u_alu (
    .a       (a_r),
    .b       (b_r),
    .op      (op_r),
    .result  (alu_result_s),
    .alu_err (alu_err_s)
  );

  // State register.
  always_ff @(posedge sw_clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_ENTER_A;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode on each accepted key.
  always_comb begin
    state_nxt_s = state_r;
    if (key_stb_s) begin
      case (state_r)
        ST_ENTER_A: begin
          if (oper_s) state_nxt_s = ST_SHOW_OP;
          else        state_nxt_s = ST_ENTER_A;
        end
        ST_SHOW_OP: begin
          if (digit_s) state_nxt_s = ST_ENTER_B;
          else         state_nxt_s = ST_SHOW_OP;
        end
        ST_ENTER_B: begin
          if (equal_s)     state_nxt_s = alu_err_s ? ST_ERROR : ST_SHOW_RES;
          else if (oper_s) state_nxt_s = alu_err_s ? ST_ERROR : ST_SHOW_OP;
          else             state_nxt_s = ST_ENTER_B;
        end
        ST_SHOW_RES: begin
          if (digit_s)     state_nxt_s = ST_ENTER_A;
          else if (oper_s) state_nxt_s = ST_SHOW_OP;
          else             state_nxt_s = ST_SHOW_RES;
        end
        ST_ERROR: begin
          if (digit_s) state_nxt_s = ST_ENTER_A;
          else         state_nxt_s = ST_ERROR;
        end
        default: state_nxt_s = ST_ENTER_A;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Operand, operator and display updates; chaining reuses the pending op before replacing it.
  always_comb begin
    a_nxt_s    = a_r;
    b_nxt_s    = b_r;
    op_nxt_s   = op_r;
    disp_nxt_s = fnd_serial;
    if (key_stb_s) begin
      case (state_r)
        ST_ENTER_A: begin
          if (digit_s) begin
            a_nxt_s    = append_digit(a_r, eBCD);
            disp_nxt_s = a_nxt_s;
          end else if (oper_s) begin
            op_nxt_s   = eBCD;
            disp_nxt_s = op_display(eBCD);
          end else begin
            disp_nxt_s = fnd_serial;
          end
        end
        ST_SHOW_OP: begin
          if (digit_s) begin
            b_nxt_s    = digit_val_s;
            disp_nxt_s = digit_val_s;
          end else if (oper_s) begin
            op_nxt_s   = eBCD;
            disp_nxt_s = op_display(eBCD);
          end else begin
            disp_nxt_s = fnd_serial;
          end
        end
        ST_ENTER_B: begin
          if (digit_s) begin
            b_nxt_s    = append_digit(b_r, eBCD);
            disp_nxt_s = b_nxt_s;
          end else if (alu_err_s) begin
            disp_nxt_s = DISP_ERROR;
          end else if (equal_s) begin
            a_nxt_s    = $signed(alu_result_s);
            disp_nxt_s = alu_result_s;
          end else begin
            a_nxt_s    = $signed(alu_result_s);
            op_nxt_s   = eBCD;
            disp_nxt_s = op_display(eBCD);
          end
        end
        ST_SHOW_RES: begin
          if (digit_s) begin
            a_nxt_s    = digit_val_s;
            disp_nxt_s = digit_val_s;
          end else if (oper_s) begin
            op_nxt_s   = eBCD;
            disp_nxt_s = op_display(eBCD);
          end else begin
            disp_nxt_s = fnd_serial;
          end
        end
        ST_ERROR: begin
          if (digit_s) begin
            a_nxt_s    = digit_val_s;
            disp_nxt_s = digit_val_s;
          end else begin
            disp_nxt_s = DISP_ERROR;
          end
        end
        default: begin
          a_nxt_s    = 32'sd0;
          b_nxt_s    = 32'sd0;
          op_nxt_s   = KEY_PLUS;
          disp_nxt_s = 32'h0000_0000;
        end
      endcase
    end else begin
      disp_nxt_s = fnd_serial;
    end
    err_nxt_s = (state_nxt_s == ST_ERROR);
  end

  // Datapath and registered outputs.
  always_ff @(posedge sw_clk or posedge rst) begin
    if (rst) begin
      a_r        <= 32'sd0;
      b_r        <= 32'sd0;
      op_r       <= KEY_PLUS;
      ebcd_q_r   <= IDLE_CODE;
      fnd_serial <= 32'h0000_0000;
      err        <= 1'b0;
      key_ack    <= 1'b0;
    end else begin
      a_r        <= a_nxt_s;
      b_r        <= b_nxt_s;
      op_r       <= op_nxt_s;
      ebcd_q_r   <= eBCD;
      fnd_serial <= disp_nxt_s;
      err        <= err_nxt_s;
      key_ack    <= key_stb_s;
    end
  end

endmodule

// File: tb/tb_calc_core.sv
// Scoreboard bench for calc_core: each key press queues its expected display/err; a monitor checks on key_ack.
module tb_calc_core;

  localparam logic [4:0] K_IDLE = 5'h1F;
  localparam logic [4:0] K_ADD  = 5'd10;
  localparam logic [4:0] K_SUB  = 5'd11;
  localparam logic [4:0] K_MUL  = 5'd12;
  localparam logic [4:0] K_DIV  = 5'd13;
  localparam logic [4:0] K_MOD  = 5'd14;
  localparam logic [4:0] K_EQ   = 5'd15;
  localparam logic [31:0] D_ADD = 32'h0010_0000;
  localparam logic [31:0] D_SUB = 32'h0020_0000;
  localparam logic [31:0] D_MUL = 32'h0030_0000;
  localparam logic [31:0] D_DIV = 32'h0040_0000;
  localparam logic [31:0] D_MOD = 32'h0050_0000;
  localparam logic [31:0] D_ERR = 32'h00EE_0000;

  logic        sw_clk = 1'b0;
  logic        rst;
  logic [4:0]  eBCD;
  logic [31:0] fnd_serial;
  logic        err;
  logic        key_ack;

  logic [32:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_resp   = 0;

  calc_core dut (
    .sw_clk     (sw_clk),
    .rst        (rst),
    .eBCD       (eBCD),
    .fnd_serial (fnd_serial),
    .err        (err),
    .key_ack    (key_ack)
  );

  always #5 sw_clk = ~sw_clk;

  // Monitor: every key_ack must match the oldest queued expectation.
  always @(negedge sw_clk) begin
    if (key_ack === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: key_ack=1 fnd_serial=%h with no key expected", fnd_serial);
      end else begin
        logic [32:0] exp;
        exp = exp_q.pop_front();
        if ({err, fnd_serial} !== exp) begin
          n_fail++;
          $display("FAIL key_resp[%0d]: got fnd_serial=%h err=%b, want fnd_serial=%h err=%b",
                   n_resp, fnd_serial, err, exp[31:0], exp[32]);
        end
      end
      n_resp++;
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic press(input logic [4:0] k, input logic [31:0] f, input logic e);
    exp_q.push_back({e, f});
    @(negedge sw_clk) eBCD = k;
    @(negedge sw_clk) eBCD = K_IDLE;
    @(negedge sw_clk);
  endtask

  task automatic do_reset();
    @(negedge sw_clk);
    #2 rst = 1'b1;
    #1;
    check("rst_fnd", fnd_serial, 32'h0000_0000);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ack", {31'd0, key_ack}, 32'd0);
    @(negedge sw_clk) rst = 1'b0;
    repeat (2) @(negedge sw_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    eBCD = K_IDLE;
    repeat (3) @(negedge sw_clk);
    check("reset_fnd", fnd_serial, 32'h0000_0000);
    check("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge sw_clk);

    // Basic add, divide by zero, recovery, chained error
    press(5'd1, 32'd1, 1'b0);
    press(5'd2, 32'd12, 1'b0);
    press(K_ADD, D_ADD, 1'b0);
    press(5'd3, 32'd3, 1'b0);
    press(K_EQ, 32'd15, 1'b0);
    press(5'd7, 32'd7, 1'b0);
    press(K_DIV, D_DIV, 1'b0);
    press(5'd0, 32'd0, 1'b0);
    press(K_EQ, D_ERR, 1'b1);
    press(K_ADD, D_ERR, 1'b1);
    press(K_EQ, D_ERR, 1'b1);
    press(5'd5, 32'd5, 1'b0);
    press(K_EQ, 32'd5, 1'b0);
    @(negedge sw_clk) eBCD = 5'd20;
    @(negedge sw_clk) eBCD = K_IDLE;
    @(negedge sw_clk);
    press(K_DIV, D_DIV, 1'b0);
    press(5'd0, 32'd0, 1'b0);
    press(K_ADD, D_ERR, 1'b1);
    press(5'd3, 32'd3, 1'b0);

    // Negative results, chaining, MOD sign, DIV truncation
    do_reset();
    press(5'd3, 32'd3, 1'b0);
    press(K_SUB, D_SUB, 1'b0);
    press(5'd8, 32'd8, 1'b0);
    press(K_EQ, -32'sd5, 1'b0);
    press(K_MUL, D_MUL, 1'b0);
    press(5'd4, 32'd4, 1'b0);
    press(K_EQ, -32'sd20, 1'b0);
    press(K_MOD, D_MOD, 1'b0);
    press(5'd3, 32'd3, 1'b0);
    press(K_EQ, -32'sd2, 1'b0);
    press(5'd1, 32'd1, 1'b0);
    press(5'd7, 32'd17, 1'b0);
    press(K_MOD, D_MOD, 1'b0);
    press(5'd5, 32'd5, 1'b0);
    press(K_EQ, 32'd2, 1'b0);
    press(K_ADD, D_ADD, 1'b0);
    press(5'd1, 32'd1, 1'b0);
    press(5'd0, 32'd10, 1'b0);
    press(K_EQ, 32'd12, 1'b0);
    press(K_SUB, D_SUB, 1'b0);
    press(5'd1, 32'd1, 1'b0);
    press(5'd9, 32'd19, 1'b0);
    press(K_DIV, D_DIV, 1'b0);
    press(5'd2, 32'd2, 1'b0);
    press(K_EQ, -32'sd3, 1'b0);

    // Entry limit
    do_reset();
    press(5'd1, 32'd1, 1'b0);
    press(5'd2, 32'd12, 1'b0);
    press(5'd3, 32'd123, 1'b0);
    press(5'd4, 32'd1234, 1'b0);
    press(5'd5, 32'd12345, 1'b0);
    press(5'd6, 32'd123456, 1'b0);
    press(5'd7, 32'd123456, 1'b0);

    // Overflow above MAX_POS, below MIN_NEG, and exact boundaries
    do_reset();
    press(5'd9, 32'd9, 1'b0);
    press(5'd8, 32'd98, 1'b0);
    press(5'd9, 32'd989, 1'b0);
    press(5'd9, 32'd9899, 1'b0);
    press(5'd9, 32'd98999, 1'b0);
    press(5'd9, 32'd989999, 1'b0);
    press(K_MUL, D_MUL, 1'b0);
    press(5'd2, 32'd2, 1'b0);
    press(K_EQ, D_ERR, 1'b1);
    press(5'd5, 32'd5, 1'b0);
    press(K_SUB, D_SUB, 1'b0);
    press(5'd9, 32'd9, 1'b0);
    press(5'd9, 32'd99, 1'b0);
    press(5'd9, 32'd999, 1'b0);
    press(5'd9, 32'd9999, 1'b0);
    press(5'd9, 32'd99999, 1'b0);
    press(5'd9, 32'd999999, 1'b0);
    press(K_EQ, D_ERR, 1'b1);
    press(5'd9, 32'd9, 1'b0);
    press(5'd9, 32'd99, 1'b0);
    press(5'd9, 32'd999, 1'b0);
    press(5'd9, 32'd9999, 1'b0);
    press(5'd9, 32'd99999, 1'b0);
    press(5'd8, 32'd999998, 1'b0);
    press(K_ADD, D_ADD, 1'b0);
    press(5'd1, 32'd1, 1'b0);
    press(K_EQ, 32'd999999, 1'b0);
    do_reset();
    press(5'd1, 32'd1, 1'b0);
    press(K_ADD, D_ADD, 1'b0);
    press(K_SUB, D_SUB, 1'b0);
    press(K_EQ, D_SUB, 1'b0);
    press(5'd1, 32'd1, 1'b0);
    press(5'd0, 32'd10, 1'b0);
    press(5'd0, 32'd100, 1'b0);
    press(5'd0, 32'd1000, 1'b0);
    press(5'd0, 32'd10000, 1'b0);
    press(5'd0, 32'd100000, 1'b0);
    press(K_EQ, -32'sd99999, 1'b0);

    // Leading zeros
    do_reset();
    press(5'd0, 32'd0, 1'b0);
    press(5'd0, 32'd0, 1'b0);
    press(5'd5, 32'd5, 1'b0);

    // Held key accepted once, repeat needs idle
    do_reset();
    exp_q.push_back({1'b0, 32'd5});
    @(negedge sw_clk) eBCD = 5'd5;
    repeat (10) @(negedge sw_clk);
    eBCD = K_IDLE;
    @(negedge sw_clk);
    press(5'd5, 32'd55, 1'b0);

    // Reset mid-operation with a key held through release
    press(K_ADD, D_ADD, 1'b0);
    press(5'd2, 32'd2, 1'b0);
    @(negedge sw_clk);
    #2 rst = 1'b1;
    eBCD = 5'd7;
    #1;
    check("midrst_fnd", fnd_serial, 32'h0000_0000);
    check("midrst_err", {31'd0, err}, 32'd0);
    repeat (2) @(negedge sw_clk);
    exp_q.push_back({1'b0, 32'd7});
    rst = 1'b0;
    repeat (4) @(negedge sw_clk);
    eBCD = K_IDLE;
    @(negedge sw_clk);
    press(K_ADD, D_ADD, 1'b0);
    press(5'd1, 32'd1, 1'b0);
    press(K_EQ, 32'd8, 1'b0);

    repeat (3) @(negedge sw_clk);
    check("pending_expectations", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
